mmio_uart_tx: RTL

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/sync_fifo.sv | 85 ++++++++
 rtl/mmio_uart_tx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the memory-mapped UART transmitter.
//   * tx_state_e     : transmit state machine encoding
//   * REG_*          : word offsets of the registers relative to BASE_ADDR
//   * STAT_* / CTRL_*: bit positions inside the STATUS and CTRL registers
//   * pack_status()  : assembles the STATUS read word from its fields
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 5;

  localparam int unsigned CTRL_TX_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  // Build the STATUS word; every bit not named here reads as zero.
  function automatic logic [31:0] pack_status(input logic       busy,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [4:0] cnt);
    logic [31:0] s;
    s                             = 32'd0;
    s[STAT_BUSY]                  = busy;
    s[STAT_FULL]                  = full;
    s[STAT_EMPTY]                 = empty;
    s[STAT_OVF]                   = ovf;
    s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock show-ahead FIFO.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset (empties the FIFO)
//   push, din     : write request and data; refused when full unless a pop
//                   happens in the same cycle
//   pop, dout     : read request; dout always presents the head entry
//   full, empty   : occupancy flags
//   count         : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped 8N1 UART transmitter with a transmit FIFO.
// Registers (word offsets from BASE_ADDR):
//   0 TXDATA : store pushes ddata_w[7:0]; loads return 0
//   1 STATUS : busy, full, empty, sticky overflow, count; store with bit3 clears overflow
//   2 CTRL   : bit0 TX_EN, bit1 IRQ_EN
// Ports:
//   CLK, RST            : clock, asynchronous active-high reset
//   daddr, ddata_w, d_w : store address/data/strobe from the core
//   d_r, ddata_r        : load strobe and combinational load data
//   tx                  : serial line (idle high), driven from a flop
//   irq                 : FIFO empty, transmitter idle and IRQ_EN set
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [9:0]  BASE_ADDR  = 10'h3F0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  daddr,
  input  logic [31:0] ddata_w,
  input  logic        d_w,
  input  logic        d_r,
  output logic [31:0] ddata_r,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        tx_en_q, tx_en_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;

  logic [9:0]    offset;
  logic          in_range;
  logic          sel_txdata;
  logic          sel_status;
  logic          sel_ctrl;
  logic          push_req;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_bits;

  // Address decode; the lower-bound test stops wrap-around aliasing near 10'h3FF.
  assign offset     = daddr - BASE_ADDR;
  assign in_range   = (daddr >= BASE_ADDR) && (offset < 10'd3);
  assign sel_txdata = in_range && (offset[1:0] == REG_TXDATA);
  assign sel_status = in_range && (offset[1:0] == REG_STATUS);
  assign sel_ctrl   = in_range && (offset[1:0] == REG_CTRL);
  assign push_req   = d_w && sel_txdata;

  assign unused_bits = ^{ddata_w[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (ddata_w[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Transmit FSM next-state: tx_d is the line level for the cycle after the edge,
  // so START drives low in the very first cycle after the pop.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_en_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = ST_START;
          baud_d   = BAUD_RELOAD;
          bit_d    = 3'd0;
          tx_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_q == 16'd0) begin
          state_d = ST_DATA;
          baud_d  = BAUD_RELOAD;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = 3'd0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        baud_d  = 16'd0;
        bit_d   = 3'd0;
      end
    endcase
  end

  // Control/overflow next-state; the overflow clear shares no address with a push.
  always_comb begin
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    if (d_w && sel_ctrl) begin
      tx_en_d  = ddata_w[CTRL_TX_EN];
      irq_en_d = ddata_w[CTRL_IRQ_EN];
    end else begin
      tx_en_d  = tx_en_q;
      irq_en_d = irq_en_q;
    end
    if (d_w && sel_status && ddata_w[STAT_OVF]) begin
      ovf_d = 1'b0;
    end else if (push_req && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Combinational load mux.
  always_comb begin
    ddata_r = 32'd0;
    if (d_r && in_range) begin
      case (offset[1:0])
        REG_STATUS: ddata_r = pack_status(state_q != ST_IDLE, fifo_full, fifo_empty,
                                          ovf_q, 5'(fifo_count));
        REG_CTRL:   ddata_r = {30'd0, irq_en_q, tx_en_q};
        default:    ddata_r = 32'd0;
      endcase
    end else begin
      ddata_r = 32'd0;
    end
  end

  // State, datapath and register flops; reset drives the line high at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx  = tx_q;
  assign irq = irq_en_q && fifo_empty && (state_q == ST_IDLE);

endmodule
